// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, 3-sample majority vote,
// per-frame latched format, and a valid/ready output holding one frame.
module uart_rx_cfg #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error,
    output logic                  Overrun_Error,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] P_ONE   = PRESCALE_W'(1);
    localparam logic [3:0]            LEN_MAX = 4'(DATA_W);

    logic                  sync1_q, rxs_q, rxs_prev_q;
    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [3:0]            len_q, len_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  par_acc_q, par_acc_d, perr_q, perr_d, serr_q, serr_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [DATA_W-1:0]     pdata_q, pdata_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d, ovr_q, ovr_d;

    logic [PRESCALE_W-1:0] half;
    logic                  smp_lo, smp_mid, smp_hi, wrap, maj, complete;

    assign half    = p_q >> 1;
    assign smp_lo  = (cnt_q == half - P_ONE);
    assign smp_mid = (cnt_q == half);
    assign smp_hi  = (cnt_q == half + P_ONE);
    assign wrap    = (cnt_q == p_q - P_ONE);
    assign maj     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = wrap ? '0 : cnt_q + P_ONE;
        bit_d     = bit_q;
        p_d       = p_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        perr_d    = perr_q;
        serr_d    = serr_q;
        s0_d      = smp_lo  ? rxs_q : s0_q;
        s1_d      = smp_mid ? rxs_q : s1_q;
        pdata_d   = pdata_q;
        dv_d      = dv_q;
        pe_d      = pe_q;
        se_d      = se_q;
        ovr_d     = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d   = START;
                    p_d       = (Prescale < P_MIN) ? P_MIN : Prescale;
                    len_d     = (DATA_LEN < 4'd5 || DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    shift_d   = '0;
                    par_acc_d = 1'b0;
                    perr_d    = 1'b0;
                    serr_d    = 1'b0;
                end
            end
            START: begin
                if (smp_hi && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (smp_hi) begin
                    shift_d   = {maj, shift_q[DATA_W-1:1]};
                    par_acc_d = par_acc_q ^ maj;
                end
                if (wrap) begin
                    if (bit_q == len_q - 4'd1) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (smp_hi) perr_d = par_acc_q ^ maj ^ par_typ_q;
                if (wrap)   state_d = STOP;
            end
            STOP: begin
                if (wrap) bit_d = bit_q + 4'd1;
                if (smp_hi) begin
                    if (!maj) serr_d = 1'b1;
                    // Leave on the last stop sample so a following start edge is not missed.
                    if (!stop2_q || bit_q == 4'd1) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        bit_d    = '0;
                        complete = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (dv_q && out_ready) dv_d = 1'b0;
        if (complete) begin
            if (!dv_q || out_ready) begin
                dv_d    = 1'b1;
                pdata_d = shift_q >> (LEN_MAX - len_q);
                pe_d    = perr_q;
                se_d    = serr_d;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (!RST) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            p_q        <= P_MIN;
            len_q      <= LEN_MAX;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= RX_IN;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            p_q        <= p_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            ovr_q      <= ovr_d;
        end
    end

    assign P_DATA        = pdata_q;
    assign data_valid    = dv_q;
    assign Parity_Error  = pe_q;
    assign Stop_Error    = se_q;
    assign Overrun_Error = ovr_q;
    assign busy          = (state_q != IDLE);

endmodule
